// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants and the fetch-buffer entry layout.
// Imported by the fetch stage, its instruction FIFO and the bench.
package riscv_pkg;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);
endpackage

// File: rtl/if_fetch_if.sv
// Request/grant/rvalid instruction-memory port between the fetch stage (master) and memory (slave).
// Responses return in request order; address must stay stable while req is high without gnt.
interface if_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/if_fifo.sv
// Synchronous in-order FIFO with flush and occupancy count; registered head, no bypass.
// Push while full is accepted only together with a pop; flush has priority over push/pop.
module if_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/if_fetch.sv
// Fetch stage: owns the PC, issues credit-limited imem requests, buffers responses for IF/ID (rvalid -> inst_valid in 1 cycle).
// if_id_stall holds the FIFO head; jmp flushes and discards in-flight responses. IF_MISALIGN_CHK_EN adds the misaligned-jmp halt.
module if_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jmp,
    input  logic [31:0]       jmp_addr,
    input  logic              if_id_stall,
    if_fetch_if.master        imem,
    output logic [31:0]       inst_addr_from_if,
    output logic [31:0]       inst_from_if,
    output logic              inst_valid,
    output logic              inst_addr_misaligned
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [31:0]      pc_q, pc_d, resp_pc_q, resp_pc_d, jmp_target;
    logic [CNT_W-1:0] outstanding_q, outstanding_d, discard_q, discard_d, fifo_count;
    logic [CNT_W:0]   inflight;
    logic             handshake, push, pop, fifo_empty, fifo_full_unused, fetch_halt;
    fetch_entry_t     push_entry, head_entry;

    assign jmp_target = {jmp_addr[31:2], 2'b00};

`ifdef IF_MISALIGN_CHK_EN
    logic misalign_q;

    always_ff @(posedge clk) begin
        if (rst)      misalign_q <= 1'b0;
        else if (jmp) misalign_q <= (jmp_addr[1:0] != 2'b00);
    end

    assign inst_addr_misaligned = misalign_q;
    assign fetch_halt           = misalign_q;
`else
    logic jmp_addr_lsb_unused;
    assign jmp_addr_lsb_unused  = ^jmp_addr[1:0];
    assign inst_addr_misaligned = 1'b0;
    assign fetch_halt           = 1'b0;
`endif

    // Flush wins over stall, so nothing is popped in a jmp cycle.
    assign pop       = inst_valid && !if_id_stall && !jmp;
    assign push      = imem.imem_rvalid && (discard_q == '0) && !jmp;
    assign inflight  = {1'b0, outstanding_q} + {1'b0, fifo_count} - {{CNT_W{1'b0}}, pop};
    assign handshake = imem.imem_req && imem.imem_gnt;

    assign imem.imem_req  = !rst && !jmp && !fetch_halt && (inflight < (CNT_W+1)'(FIFO_DEPTH));
    assign imem.imem_addr = pc_q;

    always_comb begin
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q;
        case ({handshake, imem.imem_rvalid})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
        if (handshake) pc_d = pc_q + 32'd4;
        // resp_pc_q tracks the PC of the oldest response still owed on the current path.
        if (imem.imem_rvalid) begin
            if (discard_q != '0) discard_d = discard_q - CNT_W'(1);
            else                 resp_pc_d = resp_pc_q + 32'd4;
        end
        if (jmp) begin
            pc_d      = jmp_target;
            resp_pc_d = jmp_target;
            discard_d = outstanding_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    assign push_entry = '{addr: resp_pc_q, inst: imem.imem_rdata};

    if_fifo #(
        .WIDTH (FETCH_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .flush_i (jmp),
        .rdata_o (head_entry),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full_unused)
    );

    assign inst_valid        = !fifo_empty;
    assign inst_from_if      = inst_valid ? head_entry.inst : NOP_INST;
    assign inst_addr_from_if = inst_valid ? head_entry.addr : 32'h0000_0000;
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch with a small in-order imem model (configurable gnt delay and rvalid latency).
// The model returns the request address as the instruction word.
module tb_if_fetch;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jmp = 1'b0;
    logic [31:0] jmp_addr = 32'h0;
    logic        if_id_stall = 1'b0;
    logic [31:0] inst_addr_from_if, inst_from_if;
    logic        inst_valid, inst_addr_misaligned;

    if_fetch_if imem();

    int   gnt_delay = 0;
    int   rvalid_lat = 1;
    int   wait_q = 0;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   tot_cnt = 0;
    logic ovf_seen = 1'b0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] due;
    } resp_t;
    resp_t rq[$];

    if_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .jmp                  (jmp),
        .jmp_addr             (jmp_addr),
        .if_id_stall          (if_id_stall),
        .imem                 (imem),
        .inst_addr_from_if    (inst_addr_from_if),
        .inst_from_if         (inst_from_if),
        .inst_valid           (inst_valid),
        .inst_addr_misaligned (inst_addr_misaligned)
    );

    always #5 clk = ~clk;

    assign imem.imem_gnt = imem.imem_req && (wait_q >= gnt_delay);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            rq.delete();
            wait_q           <= 0;
            imem.imem_rvalid <= 1'b0;
            imem.imem_rdata  <= 32'h0;
        end else begin
            if (imem.imem_req && imem.imem_gnt) begin
                rq.push_back('{addr: imem.imem_addr, due: 32'(cyc + rvalid_lat)});
                wait_q <= 0;
            end else if (imem.imem_req) begin
                wait_q <= wait_q + 1;
            end else begin
                wait_q <= 0;
            end
            if (rq.size() > 0 && rq[0].due == 32'(cyc + 1)) begin
                imem.imem_rvalid <= 1'b1;
                imem.imem_rdata  <= rq[0].addr;
                void'(rq.pop_front());
            end else begin
                imem.imem_rvalid <= 1'b0;
                imem.imem_rdata  <= 32'hDEAD_BEEF;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && dut.u_fifo.full_o && dut.u_fifo.push_i && !dut.u_fifo.pop_i) ovf_seen <= 1'b1;
    end

    // Leaves the bench at the negedge of the first cycle after reset release.
    task automatic do_reset(input int gd, input int lat);
        @(negedge clk);
        rst = 1'b1; jmp = 1'b0; if_id_stall = 1'b0; jmp_addr = 32'h0;
        gnt_delay = gd; rvalid_lat = lat;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; jmp = 1'b0; if_id_stall = 1'b0; gnt_delay = 0; rvalid_lat = 1;
        repeat (2) @(negedge clk);
        tot_cnt++;
        if ({inst_valid, inst_addr_misaligned, imem.imem_req} !== 3'b000)
            $display("FAIL reset_flags: got valid/mis/req=%b%b%b want 000", inst_valid, inst_addr_misaligned, imem.imem_req);
        else pass_cnt++;
        tot_cnt++;
        if (inst_from_if !== NOP_INST || inst_addr_from_if !== 32'h0)
            $display("FAIL reset_outputs: got inst=%h addr=%h want 00000013/00000000", inst_from_if, inst_addr_from_if);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        tot_cnt++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0)
            $display("FAIL first_req: got req=%b addr=%h want 1/00000000", imem.imem_req, imem.imem_addr);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            exp = 32'(4 * i);
            tot_cnt++;
            if ({inst_valid, inst_addr_from_if, inst_from_if} !== {1'b1, exp, exp})
                $display("FAIL stream[%0d]: got v=%b a=%h i=%h want v=1 a=%h i=%h",
                         i, inst_valid, inst_addr_from_if, inst_from_if, exp, exp);
            else pass_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp;
        do_reset(0, 1);
        repeat (4) @(negedge clk);
        if_id_stall = 1'b1;
        #1;
        tot_cnt++;
        if (imem.imem_req !== 1'b0)
            $display("FAIL stall_req0: got req=%b want 0", imem.imem_req);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tot_cnt++;
            if ({inst_valid, inst_addr_from_if, imem.imem_req} !== {1'b1, 32'h8, 1'b0})
                $display("FAIL stall_hold[%0d]: got v=%b a=%h req=%b want v=1 a=00000008 req=0",
                         i, inst_valid, inst_addr_from_if, imem.imem_req);
            else pass_cnt++;
        end
        if_id_stall = 1'b0;
        #1;
        tot_cnt++;
        if (imem.imem_req !== 1'b1)
            $display("FAIL stall_release_req: got req=%b want 1", imem.imem_req);
        else pass_cnt++;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            exp = 32'(8 + 4 * i);
            tot_cnt++;
            if ({inst_valid, inst_addr_from_if, inst_from_if} !== {1'b1, exp, exp})
                $display("FAIL stall_resume[%0d]: got v=%b a=%h i=%h want v=1 a=%h i=%h",
                         i, inst_valid, inst_addr_from_if, inst_from_if, exp, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_gnt_delay();
        int n;
        do_reset(2, 1);
        #1;
        for (int c = 0; c < 3; c++) begin
            tot_cnt++;
            if ({imem.imem_req, imem.imem_addr, imem.imem_gnt} !== {1'b1, 32'h0, (c == 2)})
                $display("FAIL gnt_hold[%0d]: got req=%b addr=%h gnt=%b want req=1 addr=00000000 gnt=%b",
                         c, imem.imem_req, imem.imem_addr, imem.imem_gnt, (c == 2));
            else pass_cnt++;
            @(negedge clk);
            #1;
        end
        tot_cnt++;
        if ({imem.imem_req, imem.imem_addr, imem.imem_gnt} !== {1'b1, 32'h4, 1'b0})
            $display("FAIL gnt_next_addr: got req=%b addr=%h gnt=%b want 1/00000004/0",
                     imem.imem_req, imem.imem_addr, imem.imem_gnt);
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (inst_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
            tot_cnt++;
            if ({inst_valid, inst_addr_from_if, inst_from_if} !== {1'b1, 32'(4 * k), 32'(4 * k)})
                $display("FAIL gnt_seq[%0d]: got v=%b a=%h i=%h want v=1 a=%h", k,
                         inst_valid, inst_addr_from_if, inst_from_if, 32'(4 * k));
            else pass_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_jmp_discard();
        int n;
        do_reset(0, 3);
        repeat (2) @(negedge clk);
        jmp = 1'b1; jmp_addr = 32'h100;
        #1;
        tot_cnt++;
        if (imem.imem_req !== 1'b0)
            $display("FAIL jmp_req_low: got req=%b want 0", imem.imem_req);
        else pass_cnt++;
        @(negedge clk);
        jmp = 1'b0;
        tot_cnt++;
        if (imem.imem_addr !== 32'h100 || inst_valid !== 1'b0)
            $display("FAIL jmp_pc: got addr=%h v=%b want 00000100/0", imem.imem_addr, inst_valid);
        else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (inst_valid !== 1'b1 && n < 30) begin @(negedge clk); n++; end
            tot_cnt++;
            if ({inst_valid, inst_addr_from_if, inst_from_if} !== {1'b1, 32'(256 + 4 * k), 32'(256 + 4 * k)})
                $display("FAIL jmp_discard[%0d]: got v=%b a=%h i=%h want v=1 a=%h", k,
                         inst_valid, inst_addr_from_if, inst_from_if, 32'(256 + 4 * k));
            else pass_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_jmp_stall();
        int n;
        do_reset(0, 1);
        repeat (3) @(negedge clk);
        if_id_stall = 1'b1; jmp = 1'b1; jmp_addr = 32'h100;
        #1;
        tot_cnt++;
        if (imem.imem_req !== 1'b0)
            $display("FAIL jmpstall_req: got req=%b want 0", imem.imem_req);
        else pass_cnt++;
        @(negedge clk);
        jmp = 1'b0; if_id_stall = 1'b0;
        tot_cnt++;
        if (inst_valid !== 1'b0)
            $display("FAIL jmpstall_flush: got v=%b want 0", inst_valid);
        else pass_cnt++;
        n = 0;
        while (inst_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        tot_cnt++;
        if ({inst_valid, inst_addr_from_if, inst_from_if} !== {1'b1, 32'h100, 32'h100})
            $display("FAIL jmpstall_next: got v=%b a=%h i=%h want v=1 a=00000100",
                     inst_valid, inst_addr_from_if, inst_from_if);
        else pass_cnt++;
    endtask

    task automatic test_misalign();
        int n;
        do_reset(0, 1);
        repeat (3) @(negedge clk);
        jmp = 1'b1; jmp_addr = 32'h102;
        @(negedge clk);
        jmp = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
        for (int i = 0; i < 4; i++) begin
            tot_cnt++;
            if ({inst_addr_misaligned, imem.imem_req, inst_valid} !== 3'b100)
                $display("FAIL misalign_halt[%0d]: got mis/req/v=%b%b%b want 100",
                         i, inst_addr_misaligned, imem.imem_req, inst_valid);
            else pass_cnt++;
            @(negedge clk);
        end
        jmp = 1'b1; jmp_addr = 32'h200;
        @(negedge clk);
        jmp = 1'b0;
        tot_cnt++;
        if ({inst_addr_misaligned, imem.imem_req, imem.imem_addr} !== {1'b0, 1'b1, 32'h200})
            $display("FAIL misalign_clear: got mis=%b req=%b addr=%h want 0/1/00000200",
                     inst_addr_misaligned, imem.imem_req, imem.imem_addr);
        else pass_cnt++;
        n = 0;
        while (inst_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        tot_cnt++;
        if ({inst_valid, inst_addr_from_if, inst_from_if} !== {1'b1, 32'h200, 32'h200})
            $display("FAIL misalign_fetch: got v=%b a=%h i=%h want v=1 a=00000200",
                     inst_valid, inst_addr_from_if, inst_from_if);
        else pass_cnt++;
`else
        tot_cnt++;
        if (inst_addr_misaligned !== 1'b0 || imem.imem_addr !== 32'h100)
            $display("FAIL lsb_ignored: got mis=%b addr=%h want 0/00000100",
                     inst_addr_misaligned, imem.imem_addr);
        else pass_cnt++;
        n = 0;
        while (inst_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        tot_cnt++;
        if ({inst_valid, inst_addr_from_if, inst_from_if} !== {1'b1, 32'h100, 32'h100})
            $display("FAIL lsb_fetch: got v=%b a=%h i=%h want v=1 a=00000100",
                     inst_valid, inst_addr_from_if, inst_from_if);
        else pass_cnt++;
`endif
    endtask

    task automatic test_no_overflow();
        tot_cnt++;
        if (ovf_seen !== 1'b0)
            $display("FAIL fifo_overflow: got push-when-full=%b want 0", ovf_seen);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_gnt_delay();
        test_jmp_discard();
        test_jmp_stall();
        test_misalign();
        test_no_overflow();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", pass_cnt, tot_cnt);
        $fatal(1);
    end
endmodule
